// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light sequencer and the VGA renderer:
// phase encodings, lamp patterns and default phase durations.
package traffic_pkg;

  // Phase encoding as presented on the phase output.
  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALL_RED_1 = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALL_RED_2 = 3'd5,
    PED_WALK  = 3'd6,
    FLASH     = 3'd7
  } state_t;

  // Lamp patterns, bit order {R,Y,G}.
  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  // Default timing: 100 MHz clock, durations in one-second ticks (1..63).
  localparam int DEF_TICK_DIV = 100_000_000;
  localparam int DEF_GREEN_S  = 10;
  localparam int DEF_YELLOW_S = 3;
  localparam int DEF_ALLRED_S = 1;
  localparam int DEF_PED_S    = 8;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV clocks.
// The sequencer clears it on every phase change so each phase starts on a
// fresh tick boundary.
module tick_prescaler
  import traffic_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int              CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_count;

  assign tick = (r_count == LAST);

  // Count 0..TICK_DIV-1, wrapping on the tick or restarting on clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clear || tick) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/traffic_light_sequencer.sv
// Two-way intersection controller with pedestrian phase and flashing-yellow
// mode. All outputs are registers loaded from the next-state values, so they
// change on the same edge as the phase and never follow inputs combinationally.
module traffic_light_sequencer
  import traffic_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int GREEN_S  = DEF_GREEN_S,
  parameter int YELLOW_S = DEF_YELLOW_S,
  parameter int ALLRED_S = DEF_ALLRED_S,
  parameter int PED_S    = DEF_PED_S
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ped_req,
  input  logic       flash_en,
  output logic [2:0] ns_light,
  output logic [2:0] ew_light,
  output logic       ped_walk,
  output logic [2:0] phase,
  output logic [5:0] sec_left
);

  state_t     r_state, w_next_state;
  logic [5:0] r_sec_left, w_next_sec_left;
  logic [2:0] r_ns_light, w_next_ns_light;
  logic [2:0] r_ew_light, w_next_ew_light;
  logic       r_ped_walk, w_next_ped_walk;
  logic       r_ped_pending, w_next_ped_pending;
  logic       r_flash_off, w_next_flash_off;
  logic       w_tick;
  logic       w_change;
  logic       w_last_tick;

  // Length of a phase in ticks; FLASH has no countdown.
  function automatic logic [5:0] phase_len(input state_t s);
    case (s)
      NS_GREEN, EW_GREEN:   phase_len = 6'(GREEN_S);
      NS_YELLOW, EW_YELLOW: phase_len = 6'(YELLOW_S);
      PED_WALK:             phase_len = 6'(PED_S);
      FLASH:                phase_len = 6'd0;
      default:              phase_len = 6'(ALLRED_S);
    endcase
  endfunction

  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (w_change),
    .tick  (w_tick)
  );

  assign w_last_tick = w_tick && (r_sec_left == 6'd1);
  assign w_change    = (w_next_state != r_state);

  // Phase and registered outputs; reset parks the lights in a full all-red.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ALL_RED_2;
      r_sec_left    <= 6'(ALLRED_S);
      r_ns_light    <= LAMP_RED;
      r_ew_light    <= LAMP_RED;
      r_ped_walk    <= 1'b0;
      r_ped_pending <= 1'b0;
      r_flash_off   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values; blocking here would chain updates within one edge.
      r_state       <= w_next_state;
      r_sec_left    <= w_next_sec_left;
      r_ns_light    <= w_next_ns_light;
      r_ew_light    <= w_next_ew_light;
      r_ped_walk    <= w_next_ped_walk;
      r_ped_pending <= w_next_ped_pending;
      r_flash_off   <= w_next_flash_off;
    end
  end

  // Next phase: flash_en preempts everything, otherwise advance on the last tick.
  always_comb begin
    // NOTE: default assignment first so no path through the case leaves the
    // signal unassigned, which would otherwise infer a latch.
    w_next_state = r_state;
    if (flash_en) begin
      w_next_state = FLASH;
    end else begin
      case (r_state)
        NS_GREEN:  if (w_last_tick) w_next_state = NS_YELLOW;
        NS_YELLOW: if (w_last_tick) w_next_state = ALL_RED_1;
        ALL_RED_1: if (w_last_tick) w_next_state = EW_GREEN;
        EW_GREEN:  if (w_last_tick) w_next_state = EW_YELLOW;
        EW_YELLOW: if (w_last_tick) w_next_state = ALL_RED_2;
        ALL_RED_2: if (w_last_tick) w_next_state = r_ped_pending ? PED_WALK : NS_GREEN;
        PED_WALK:  if (w_last_tick) w_next_state = NS_GREEN;
        FLASH:     w_next_state = ALL_RED_2;
        default:   w_next_state = ALL_RED_2;
      endcase
    end
  end

  // Next values of the countdown, pending request, flash phase and lamps.
  always_comb begin
    w_next_ped_pending = r_ped_pending;
    w_next_sec_left    = r_sec_left;
    w_next_flash_off   = r_flash_off;
    w_next_ns_light    = LAMP_RED;
    w_next_ew_light    = LAMP_RED;
    w_next_ped_walk    = 1'b0;

    // Entry to the walk phase consumes the request, even if one arrives now.
    if (w_next_state == PED_WALK && r_state != PED_WALK) begin
      w_next_ped_pending = 1'b0;
    end else if (ped_req) begin
      w_next_ped_pending = 1'b1;
    end

    if (w_change) begin
      w_next_sec_left = phase_len(w_next_state);
    end else if (w_tick && r_state != FLASH) begin
      w_next_sec_left = r_sec_left - 6'd1;
    end

    // Flashing starts lit on entry and alternates on every tick.
    if (w_change) begin
      w_next_flash_off = 1'b0;
    end else if (w_tick && r_state == FLASH) begin
      w_next_flash_off = ~r_flash_off;
    end

    case (w_next_state)
      NS_GREEN:  w_next_ns_light = LAMP_GRN;
      NS_YELLOW: w_next_ns_light = LAMP_YEL;
      EW_GREEN:  w_next_ew_light = LAMP_GRN;
      EW_YELLOW: w_next_ew_light = LAMP_YEL;
      PED_WALK:  w_next_ped_walk = 1'b1;
      FLASH: begin
        w_next_ns_light = w_next_flash_off ? LAMP_OFF : LAMP_YEL;
        w_next_ew_light = w_next_flash_off ? LAMP_OFF : LAMP_YEL;
      end
      default: ;
    endcase
  end

  assign ns_light = r_ns_light;
  assign ew_light = r_ew_light;
  assign ped_walk = r_ped_walk;
  assign phase    = r_state;
  assign sec_left = r_sec_left;

endmodule

// File: tb/tb_traffic_light_sequencer.sv
// Scoreboard bench: the driver advances a phase-timeline model each cycle and
// queues the expected outputs; a negedge monitor pops and compares, and also
// checks lamp safety invariants.
module tb_traffic_light_sequencer;
  import traffic_pkg::*;

  localparam int TD  = 4;
  localparam int G   = 3;
  localparam int Y   = 2;
  localparam int AR  = 1;
  localparam int PED = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       ped_req;
  logic       flash_en;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       ped_walk;
  logic [2:0] phase;
  logic [5:0] sec_left;

  typedef struct packed {
    logic [2:0] ph;
    logic [2:0] ns;
    logic [2:0] ew;
    logic       walk;
    logic [5:0] sec;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: phase, cycles elapsed in it, pending walk request.
  state_t m_st   = ALL_RED_2;
  int     m_cyc  = 0;
  bit     m_pend = 1'b0;

  traffic_light_sequencer #(
    .TICK_DIV (TD),
    .GREEN_S  (G),
    .YELLOW_S (Y),
    .ALLRED_S (AR),
    .PED_S    (PED)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .ped_req  (ped_req),
    .flash_en (flash_en),
    .ns_light (ns_light),
    .ew_light (ew_light),
    .ped_walk (ped_walk),
    .phase    (phase),
    .sec_left (sec_left)
  );

  always #5 clk = ~clk;

  function automatic int dur_of(input state_t s);
    case (s)
      NS_GREEN, EW_GREEN:   return G;
      NS_YELLOW, EW_YELLOW: return Y;
      PED_WALK:             return PED;
      FLASH:                return 0;
      default:              return AR;
    endcase
  endfunction

  function automatic state_t after(input state_t s, input bit pend);
    case (s)
      NS_GREEN:  return NS_YELLOW;
      NS_YELLOW: return ALL_RED_1;
      ALL_RED_1: return EW_GREEN;
      EW_GREEN:  return EW_YELLOW;
      EW_YELLOW: return ALL_RED_2;
      ALL_RED_2: return pend ? PED_WALK : NS_GREEN;
      default:   return NS_GREEN;
    endcase
  endfunction

  function automatic void model_reset();
    m_st   = ALL_RED_2;
    m_cyc  = 0;
    m_pend = 1'b0;
  endfunction

  function automatic void model_step(input logic p, input logic f);
    state_t nxt  = m_st;
    int     ncyc = m_cyc + 1;
    if (f) begin
      if (m_st != FLASH) begin
        nxt  = FLASH;
        ncyc = 0;
      end
    end else if (m_st == FLASH) begin
      nxt  = ALL_RED_2;
      ncyc = 0;
    end else if (ncyc >= dur_of(m_st) * TD) begin
      nxt  = after(m_st, m_pend);
      ncyc = 0;
    end
    if (nxt == PED_WALK && m_st != PED_WALK) m_pend = 1'b0;
    else if (p)                             m_pend = 1'b1;
    m_st  = nxt;
    m_cyc = ncyc;
  endfunction

  function automatic exp_t model_expect();
    exp_t e;
    e.ph   = m_st;
    e.ns   = LAMP_RED;
    e.ew   = LAMP_RED;
    e.walk = (m_st == PED_WALK);
    e.sec  = (m_st == FLASH) ? 6'd0 : 6'(dur_of(m_st) - m_cyc / TD);
    case (m_st)
      NS_GREEN:  e.ns = LAMP_GRN;
      NS_YELLOW: e.ns = LAMP_YEL;
      EW_GREEN:  e.ew = LAMP_GRN;
      EW_YELLOW: e.ew = LAMP_YEL;
      FLASH: begin
        e.ns = ((m_cyc / TD) % 2 == 1) ? LAMP_OFF : LAMP_YEL;
        e.ew = e.ns;
      end
      default: ;
    endcase
    return e;
  endfunction

  // One clock of stimulus. late_rst asserts reset just after the edge, so
  // only an asynchronous reset can produce the queued reset values.
  task automatic cycle(input logic p, input logic f, input logic rs_n, input bit late_rst);
    ped_req  = p;
    flash_en = f;
    reset    = rs_n;
    if (!rs_n) model_reset();
    else       model_step(p, f);
    if (late_rst) model_reset();
    exp_q.push_back(model_expect());
    @(posedge clk);
    if (late_rst) begin
      #1;
      reset = 1'b0;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic wait_model(input state_t s, input int cyc, input int budget);
    int k = 0;
    while (!(m_st == s && m_cyc == cyc) && k < budget) begin
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      k++;
    end
    n_checks++;
    if (!(m_st == s && m_cyc == cyc)) begin
      n_fail++;
      $display("FAIL wait_phase: reached phase %0d cycle %0d, required phase %0d cycle %0d", m_st, m_cyc, s, cyc);
    end
  endtask

  // Monitor: compare every presented output against the queued expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if ({phase, ns_light, ew_light, ped_walk, sec_left} !== e) begin
        n_fail++;
        $display("FAIL outputs t=%0t: got ph=%0d ns=%b ew=%b walk=%b sec=%0d, expected ph=%0d ns=%b ew=%b walk=%b sec=%0d",
                 $time, phase, ns_light, ew_light, ped_walk, sec_left, e.ph, e.ns, e.ew, e.walk, e.sec);
      end
      n_checks++;
      if (!($onehot0(ns_light) && $onehot0(ew_light) &&
            !(ns_light == LAMP_GRN && ew_light == LAMP_GRN) &&
            (!ped_walk || (ns_light == LAMP_RED && ew_light == LAMP_RED)))) begin
        n_fail++;
        $display("FAIL safety t=%0t: got ns=%b ew=%b walk=%b, required one-hot/off lamps, no double green, walk only on all-red",
                 $time, ns_light, ew_light, ped_walk);
      end
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  initial begin
    reset    = 1'b0;
    ped_req  = 1'b0;
    flash_en = 1'b0;
    @(negedge clk);
    #1;

    // Reset held, then release and run the plain cycle twice over.
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    idle(110);

    // Single-cycle pedestrian request during EW_GREEN.
    wait_model(EW_GREEN, 5, 100);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    idle(70);

    // Request held high across entry to PED_WALK: a second walk follows.
    wait_model(EW_GREEN, 0, 100);
    for (int i = 0; i < 30; i++) cycle(1'b1, 1'b0, 1'b1, 1'b0);
    idle(100);

    // Flash raised at cycle 2 of NS_GREEN, held, then released.
    wait_model(NS_GREEN, 1, 100);
    for (int i = 0; i < 18; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    idle(30);

    // Reset mid-PED_WALK with a fresh request pending: the request is lost.
    wait_model(EW_GREEN, 2, 100);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    wait_model(PED_WALK, 2, 100);
    cycle(1'b1, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 1'b0);
    idle(70);

    // Reset mid-FLASH.
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idle(30);

    // Randomized traffic: sparse ped requests, sticky flash periods, rare resets.
    begin
      logic f = 1'b0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 149) == 0) f = ~f;
        if ($urandom_range(0, 399) == 0) begin
          cycle(1'b0, f, 1'b1, 1'b1);
          cycle(1'b0, f, 1'b0, 1'b0);
        end else begin
          cycle(($urandom_range(0, 19) == 0), f, 1'b1, 1'b0);
        end
      end
    end
    idle(20);

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d unchecked expectations, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
